// File: rtl/multi_credit_counter.sv
// multi_credit_counter: NUM_CH credit counters sharing one method interface.
// Each cycle, one channel can be incremented, one decremented (guarded by RDY),
// one conditionally decremented, and one cleared.
// Optional macro CREDIT_COUNTER_SATURATE_EN: saturate at all-ones and set a
// sticky per-channel overflow flag. When it is undefined, counts wrap and
// overflow reads 0.

module credit_lane #(
  parameter int count_sz = 10,
  parameter int INIT_VAL = 0
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                inc_hit,
  input  logic [count_sz-1:0] inc_v,
  input  logic                dec_hit,
  input  logic [count_sz-1:0] dec_v,
  input  logic                mdec_hit,
  input  logic [count_sz-1:0] mdec_v,
  input  logic                clr_hit,
  output logic [count_sz-1:0] cnt,
  output logic                pos,
  output logic                ovf
);
  localparam logic [count_sz-1:0] INIT = count_sz'(INIT_VAL);
`ifdef CREDIT_COUNTER_SATURATE_EN
  // The carry bit marks a result above all-ones.
  localparam int SW = count_sz + 1;
`else
  // Modulo wrap discards the carry, so the sum is kept at count width.
  localparam int SW = count_sz;
`endif

  logic [SW-1:0]       sum;
  logic [count_sz-1:0] nxt;

  // Next count: every term is taken against the pre-edge count.
  always_comb begin
    sum = SW'(cnt);
    if (inc_hit)  sum = sum + SW'(inc_v);
    if (dec_hit)  sum = sum - SW'(dec_v);
    if (mdec_hit) sum = sum - SW'(mdec_v);
`ifdef CREDIT_COUNTER_SATURATE_EN
    nxt = sum[SW-1] ? '1 : sum[count_sz-1:0];
`else
    nxt = sum;
`endif
  end

  // Count and positive flag; clear discards all other methods on this lane.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cnt <= INIT;
      pos <= (INIT != '0);
    end else if (clr_hit) begin
      cnt <= INIT;
      pos <= (INIT != '0);
    end else begin
      cnt <= nxt;
      pos <= (nxt != '0);
    end
  end

`ifdef CREDIT_COUNTER_SATURATE_EN
  // Sticky overflow, cleared only by reset or clear of this lane.
  always_ff @(posedge CLK) begin
    if (!nRST)          ovf <= 1'b0;
    else if (clr_hit)   ovf <= 1'b0;
    else if (sum[SW-1]) ovf <= 1'b1;
  end
`else
  assign ovf = 1'b0;
`endif
endmodule

module multi_credit_counter #(
  parameter int count_sz = 10,
  parameter int NUM_CH   = 4,
  parameter int CH_W     = 2,
  parameter int INIT_VAL = 0
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                increment__ENA,
  input  logic [CH_W-1:0]     increment_ch,
  input  logic [count_sz-1:0] increment_v,
  output logic                increment__RDY,
  input  logic                decrement__ENA,
  input  logic [CH_W-1:0]     decrement_ch,
  input  logic [count_sz-1:0] decrement_v,
  output logic                decrement__RDY,
  input  logic                maybeDecrement__ENA,
  input  logic [CH_W-1:0]     maybeDecrement_ch,
  input  logic [count_sz-1:0] maybeDecrement_v,
  output logic                maybeDecrement,
  output logic                maybeDecrement__RDY,
  input  logic                clear__ENA,
  input  logic [CH_W-1:0]     clear_ch,
  output logic                clear__RDY,
  input  logic [CH_W-1:0]     read_ch,
  output logic [count_sz-1:0] read,
  output logic [NUM_CH-1:0]   positive,
  output logic [NUM_CH-1:0]   overflow
);
  typedef struct packed {
    logic                ena;
    logic [CH_W-1:0]     ch;
    logic [count_sz-1:0] v;
  } req_t;

  req_t inc_req, dec_req, mdec_req;
  logic [NUM_CH-1:0][count_sz-1:0] cnt_arr;
  logic mdec_take;

  assign inc_req  = '{increment__ENA, increment_ch, increment_v};
  assign dec_req  = '{decrement__ENA, decrement_ch, decrement_v};
  assign mdec_req = '{maybeDecrement__ENA, maybeDecrement_ch, maybeDecrement_v};

  assign increment__RDY      = 1'b1;
  assign maybeDecrement__RDY = 1'b1;
  assign clear__RDY          = 1'b1;

  // Guards and read port all see the pre-edge counts.
  always_comb begin
    read           = cnt_arr[read_ch];
    decrement__RDY = cnt_arr[dec_req.ch] >= dec_req.v;
    // A same-channel decrement owns the credits; maybeDecrement backs off.
    maybeDecrement = (cnt_arr[mdec_req.ch] >= mdec_req.v) &&
                     !(dec_req.ena && dec_req.ch == mdec_req.ch);
    mdec_take      = mdec_req.ena && maybeDecrement;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    credit_lane #(.count_sz(count_sz), .INIT_VAL(INIT_VAL)) u_lane (
      .CLK      (CLK),
      .nRST     (nRST),
      .inc_hit  (inc_req.ena && inc_req.ch == CH_W'(i)),
      .inc_v    (inc_req.v),
      .dec_hit  (dec_req.ena && dec_req.ch == CH_W'(i)),
      .dec_v    (dec_req.v),
      .mdec_hit (mdec_take && mdec_req.ch == CH_W'(i)),
      .mdec_v   (mdec_req.v),
      .clr_hit  (clear__ENA && clear_ch == CH_W'(i)),
      .cnt      (cnt_arr[i]),
      .pos      (positive[i]),
      .ovf      (overflow[i])
    );
  end

`ifndef SYNTHESIS
  // Decrementing without RDY would underflow the channel.
  always_ff @(posedge CLK) begin
    if (nRST && decrement__ENA)
      assert (decrement__RDY) else $error("decrement__ENA without decrement__RDY");
  end
`endif
endmodule

// File: tb/tb_multi_credit_counter.sv
// Directed bench for multi_credit_counter (count_sz=10, NUM_CH=4, INIT_VAL=0).
module tb_multi_credit_counter;
  logic       CLK = 1'b0;
  logic       nRST;
  logic       inc_ena, dec_ena, mdec_ena, clr_ena;
  logic [1:0] inc_ch, dec_ch, mdec_ch, clr_ch, rd_ch;
  logic [9:0] inc_v, dec_v, mdec_v;
  logic       inc_rdy, dec_rdy, mdec, mdec_rdy, clr_rdy;
  logic [9:0] rd;
  logic [3:0] positive, overflow;
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  multi_credit_counter dut (
    .CLK(CLK), .nRST(nRST),
    .increment__ENA(inc_ena), .increment_ch(inc_ch), .increment_v(inc_v),
    .increment__RDY(inc_rdy),
    .decrement__ENA(dec_ena), .decrement_ch(dec_ch), .decrement_v(dec_v),
    .decrement__RDY(dec_rdy),
    .maybeDecrement__ENA(mdec_ena), .maybeDecrement_ch(mdec_ch),
    .maybeDecrement_v(mdec_v), .maybeDecrement(mdec),
    .maybeDecrement__RDY(mdec_rdy),
    .clear__ENA(clr_ena), .clear_ch(clr_ch), .clear__RDY(clr_rdy),
    .read_ch(rd_ch), .read(rd), .positive(positive), .overflow(overflow)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and drop all method enables.
  task automatic tick();
    @(posedge CLK); #1;
    inc_ena = 0; dec_ena = 0; mdec_ena = 0; clr_ena = 0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] ch, input int exp);
    rd_ch = ch; #1;
    check(tag, int'(rd), exp);
  endtask

  initial begin
    nRST = 0; inc_ena = 0; dec_ena = 0; mdec_ena = 0; clr_ena = 0;
    inc_ch = 0; dec_ch = 0; mdec_ch = 0; clr_ch = 0; rd_ch = 0;
    inc_v = 0; dec_v = 0; mdec_v = 0;
    tick(); tick();
    nRST = 1;

    // Reset state
    rd_chk("rst_rd0", 0, 0); rd_chk("rst_rd1", 1, 0);
    rd_chk("rst_rd2", 2, 0); rd_chk("rst_rd3", 3, 0);
    check("rst_pos", int'(positive), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rdy_const", int'({inc_rdy, mdec_rdy, clr_rdy}), 7);

    // inc ch1 +5: read is pre-update in the same cycle
    inc_ena = 1; inc_ch = 1; inc_v = 5;
    rd_chk("inc_preupd", 1, 0);
    tick();
    rd_chk("inc_ch1", 1, 5);
    check("inc_pos", int'(positive), 4'b0010);

    // dec ch1 -3
    dec_ch = 1; dec_v = 3; #1;
    check("dec_rdy", int'(dec_rdy), 1);
    dec_ena = 1;
    tick();
    rd_chk("dec_ch1", 1, 2);
    dec_ch = 1; dec_v = 3; #1;
    check("dec_rdy_low", int'(dec_rdy), 0);

    // ch2=4 then inc+2, dec-4, mdec 1 on ch2 together
    inc_ena = 1; inc_ch = 2; inc_v = 4;
    tick();
    inc_ena = 1; inc_ch = 2; inc_v = 2;
    dec_ena = 1; dec_ch = 2; dec_v = 4;
    mdec_ena = 1; mdec_ch = 2; mdec_v = 1; #1;
    check("mix_mdec", int'(mdec), 0);
    tick();
    rd_chk("mix_ch2", 2, 2);

    // ch0=3; mdec 5 refused, mdec 3 taken
    inc_ena = 1; inc_ch = 0; inc_v = 3;
    tick();
    mdec_ena = 1; mdec_ch = 0; mdec_v = 5; #1;
    check("mdec_no", int'(mdec), 0);
    tick();
    rd_chk("mdec_no_ch0", 0, 3);
    mdec_ena = 1; mdec_ch = 0; mdec_v = 3; #1;
    check("mdec_yes", int'(mdec), 1);
    tick();
    rd_chk("mdec_yes_ch0", 0, 0);
    check("mdec_pos", int'(positive), 4'b0110);

    // Parallel methods on distinct channels
    inc_ena = 1; inc_ch = 3; inc_v = 7;
    dec_ena = 1; dec_ch = 1; dec_v = 2;
    mdec_ena = 1; mdec_ch = 2; mdec_v = 2; #1;
    check("par_mdec", int'(mdec), 1);
    tick();
    rd_chk("par_ch3", 3, 7); rd_chk("par_ch1", 1, 0); rd_chk("par_ch2", 2, 0);
    check("par_pos", int'(positive), 4'b1000);

    // Top of range and overflow on ch3
    inc_ena = 1; inc_ch = 3; inc_v = 1016;
    tick();
    rd_chk("max_ch3", 3, 1023);
    check("max_ovf", int'(overflow), 0);
    inc_ena = 1; inc_ch = 3; inc_v = 3;
    tick();
`ifdef CREDIT_COUNTER_SATURATE_EN
    rd_chk("ovf_ch3", 3, 1023);
    check("ovf_flag", int'(overflow), 4'b1000);
    inc_ena = 1; inc_ch = 0; inc_v = 1;
    tick();
    check("ovf_sticky", int'(overflow), 4'b1000);
`else
    rd_chk("wrap_ch3", 3, 2);
    check("wrap_ovf", int'(overflow), 0);
`endif
    clr_ena = 1; clr_ch = 3;
    tick();
    rd_chk("clr_ch3", 3, 0);
    check("clr_ovf", int'(overflow), 0);

    // clear ch1 beats a concurrent inc
    inc_ena = 1; inc_ch = 1; inc_v = 4;
    tick();
    rd_chk("pre_clr_ch1", 1, 4);
    clr_ena = 1; clr_ch = 1; inc_ena = 1; inc_ch = 1; inc_v = 7;
    tick();
    rd_chk("clr_inc_ch1", 1, 0);
    check("clr_pos1", int'(positive[1]), 0);

    // reset beats clear and inc
    inc_ena = 1; inc_ch = 2; inc_v = 9;
    tick();
    rd_chk("pre_rst_ch2", 2, 9);
    nRST = 0;
    clr_ena = 1; clr_ch = 1; inc_ena = 1; inc_ch = 1; inc_v = 7;
    tick();
    nRST = 1;
    rd_chk("rst2_ch1", 1, 0); rd_chk("rst2_ch2", 2, 0);
    check("rst2_pos", int'(positive), 0);
    check("rst2_ovf", int'(overflow), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
